// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 8-digit seven-segment scanner.
// Three 6-bit field codes (left/middle/right) are captured once per frame
// and decoded into two characters each; digits 6 and 7 are always blank.
// Optional build macro SEG_BLANK_EN: inserts a BLANK_CYC-cycle dark gap at
// the start of every digit slot to suppress ghosting.
module seg_scan_driver #(
  parameter int CLK_HZ    = 100000000,
  parameter int SCAN_HZ   = 1000,
  parameter int BLANK_CYC = 2
) (
  input  logic       cp,
  input  logic       nCR,
  input  logic [5:0] left,
  input  logic [5:0] middle,
  input  logic [5:0] right,
  output logic [7:0] showLeft,
  output logic [7:0] showRight
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  // Elaboration-time sanity check on the divider configuration.
  if (DIV < 4 || BLANK_CYC < 0) begin : g_cfg_check
    $error("seg_scan_driver: DIV must be >= 4 and BLANK_CYC non-negative");
  end

  localparam logic [7:0] CH_H     = 8'h76;
  localparam logic [7:0] CH_E     = 8'h79;
  localparam logic [7:0] CH_L     = 8'h38;
  localparam logic [7:0] CH_O     = 8'h3F;
  localparam logic [7:0] CH_P     = 8'h73;
  localparam logic [7:0] CH_A     = 8'h77;
  localparam logic [7:0] CH_R     = 8'h50;
  localparam logic [7:0] CH_DASH  = 8'h40;
  localparam logic [7:0] CH_BLANK = 8'h00;
  localparam logic [7:0] CH_FULL  = 8'hFF;

  // Decimal digit to segment pattern (dp off).
  function automatic logic [7:0] digit_seg(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'h3F;
      4'd1:    s = 8'h06;
      4'd2:    s = 8'h5B;
      4'd3:    s = 8'h4F;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'h6D;
      4'd6:    s = 8'h7D;
      4'd7:    s = 8'h07;
      4'd8:    s = 8'h7F;
      4'd9:    s = 8'h6F;
      default: s = CH_BLANK;
    endcase
    return s;
  endfunction

  // Field code to the character shown on its tens or ones digit.
  // The decimal split is a compare chain, so no divider is built.
  function automatic logic [7:0] code_seg(input logic [5:0] code, input logic tens);
    logic [7:0] s;
    logic [3:0] t;
    logic [5:0] base;
    s = CH_BLANK;
    if (code <= 6'd54) begin
      if      (code >= 6'd50) begin t = 4'd5; base = 6'd50; end
      else if (code >= 6'd40) begin t = 4'd4; base = 6'd40; end
      else if (code >= 6'd30) begin t = 4'd3; base = 6'd30; end
      else if (code >= 6'd20) begin t = 4'd2; base = 6'd20; end
      else if (code >= 6'd10) begin t = 4'd1; base = 6'd10; end
      else                    begin t = 4'd0; base = 6'd0;  end
      s = tens ? digit_seg(t) : digit_seg(4'(code - base));
    end else begin
      case (code)
        6'd55:   s = CH_BLANK;
        6'd56:   s = CH_FULL;
        6'd57:   s = tens ? CH_P : CH_A;
        6'd58:   s = tens ? CH_E : CH_R;
        6'd59:   s = tens ? CH_H : CH_E;
        6'd60:   s = CH_L;
        6'd61:   s = tens ? CH_O : CH_BLANK;
        default: s = CH_DASH;
      endcase
    end
    return s;
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d, idx_nxt;
  logic          tick, wrap;
  logic [5:0]    left_q, middle_q, right_q;
  logic [5:0]    cur_l, cur_m, cur_r, slot_code;
  logic [7:0]    slot_seg, slot_an;
  logic [7:0]    seg_q, an_q;

  // Prescaler, slot index and frame-wrap detection.
  always_comb begin
    tick    = (presc_q == PW'(DIV - 1));
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_nxt = idx_q + 3'd1;
    idx_d   = tick ? idx_nxt : idx_q;
    wrap    = tick && (idx_q == 3'd7);
  end

  // Pattern for the slot about to start; at a wrap slot 0 must use the
  // codes being latched on this same edge, so bypass the shadow registers.
  always_comb begin
    cur_l     = wrap ? left   : left_q;
    cur_m     = wrap ? middle : middle_q;
    cur_r     = wrap ? right  : right_q;
    slot_code = 6'd55;
    case (idx_nxt[2:1])
      2'd0:    slot_code = cur_r;
      2'd1:    slot_code = cur_m;
      2'd2:    slot_code = cur_l;
      default: slot_code = 6'd55;
    endcase
    if (idx_nxt < 3'd6) begin
      slot_seg = code_seg(slot_code, idx_nxt[0]);
      slot_an  = ~(8'd1 << idx_nxt);
    end else begin
      slot_seg = CH_BLANK;
      slot_an  = 8'hFF;
    end
  end

  // Scan state and per-frame shadow capture of the field codes.
  always_ff @(posedge cp or negedge nCR) begin
    if (!nCR) begin
      presc_q  <= '0;
      idx_q    <= 3'd7;
      left_q   <= 6'd55;
      middle_q <= 6'd55;
      right_q  <= 6'd55;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      if (wrap) begin
        left_q   <= left;
        middle_q <= middle;
        right_q  <= right;
      end
    end
  end

`ifdef SEG_BLANK_EN
  logic [PW-1:0] since_q;
  logic [7:0]    hold_seg_q, hold_an_q;

  // Dark for the first BLANK_CYC cycles of a slot, then the held pattern.
  always_ff @(posedge cp or negedge nCR) begin
    if (!nCR) begin
      since_q    <= '0;
      hold_seg_q <= CH_BLANK;
      hold_an_q  <= 8'hFF;
      seg_q      <= CH_BLANK;
      an_q       <= 8'hFF;
    end else if (tick) begin
      since_q    <= '0;
      hold_seg_q <= slot_seg;
      hold_an_q  <= slot_an;
      if (BLANK_CYC > 0) begin
        seg_q <= CH_BLANK;
        an_q  <= 8'hFF;
      end else begin
        seg_q <= slot_seg;
        an_q  <= slot_an;
      end
    end else begin
      if (since_q != PW'(DIV - 1)) since_q <= since_q + 1'b1;
      if ((BLANK_CYC > 0) && (since_q == PW'(BLANK_CYC - 1))) begin
        seg_q <= hold_seg_q;
        an_q  <= hold_an_q;
      end
    end
  end
`else
  // Anodes and segments switch directly at the slot tick.
  always_ff @(posedge cp or negedge nCR) begin
    if (!nCR) begin
      seg_q <= CH_BLANK;
      an_q  <= 8'hFF;
    end else if (tick) begin
      seg_q <= slot_seg;
      an_q  <= slot_an;
    end
  end
`endif

  assign showLeft  = seg_q;
  assign showRight = an_q;

endmodule
